sif_mc_fwd: RTL and testbench

Parametrised multi-channel successor of the single-port SIF.
- The xa port writes and reads a local register file of NUM_CH x DEPTH words.
- Every accepted write is also forwarded to one of NUM_CH wa output channels, selected by address.
- Each wa channel has its own FIFO and a valid/ready handshake, so a slow downstream consumer no longer loses writes.

---
 rtl/sif_pkg.sv | 20 ++
 rtl/sif_fifo.sv | 63 ++++++
 rtl/sif_mc_fwd.sv | 133 +++++++++++++
 tb/tb_sif_mc_fwd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sif_pkg.sv
// Shared types and helpers for the multi-channel SIF forwarder.
// op_t is also used by the testbench to describe stimulus.
package sif_pkg;

  localparam int SIF_AW_DEF = 16;
  localparam int SIF_DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESET = 2'd3
  } op_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sif_fifo.sv
// Synchronous FIFO with extra-MSB pointers; dout reads 0 while empty.
// A push into a full FIFO is accepted only together with a pop.
module sif_fifo
  import sif_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [clog2_min1(DEPTH):0] count
);

  localparam int IW = clog2_min1(DEPTH);
  localparam int PW = IW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Handshake qualification and status flags
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
    count     = wr_ptr_r - rd_ptr_r;
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    if (empty) begin
      dout = {W{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r[IW-1:0]];
    end
  end

  // Storage and pointer update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[IW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

endmodule

// File: rtl/sif_mc_fwd.sv
// Multi-channel SIF: local register file on the xa port, every accepted
// write forwarded through a per-channel FIFO to a valid/ready wa port.
module sif_mc_fwd
  import sif_pkg::*;
#(
  parameter int AW         = SIF_AW_DEF,
  parameter int DW         = SIF_DW_DEF,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 xa_wr_s,
  input  logic                 xa_rd_s,
  input  logic [AW-1:0]        xa_addr,
  input  logic [DW-1:0]        xa_data_wr,
  output logic [DW-1:0]        xa_data_rd,
  output logic                 xa_rd_vld,
  output logic                 xa_err,
  output logic [NUM_CH-1:0]    wa_valid,
  input  logic [NUM_CH-1:0]    wa_ready,
  output logic [NUM_CH*AW-1:0] wa_addr,
  output logic [NUM_CH*DW-1:0] wa_data_wr
);

  localparam int IDX_W = clog2_min1(DEPTH);
  localparam int CH_W  = clog2_min1(NUM_CH);
  localparam int SEL_W = IDX_W + CH_W;
  localparam int CW    = clog2_min1(FIFO_DEPTH) + 1;

  op_t               op_s;
  logic              conflict_s;
  logic              legal_s;
  logic [SEL_W-1:0]  sel_s;
  logic [CH_W-1:0]   ch_s;
  logic              can_push_s;
  logic              wr_ok_s;
  logic              err_next_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] full_s;
  logic [CW-1:0]     count_s [NUM_CH];
  logic [AW+DW-1:0]  dout_s  [NUM_CH];

  logic [DW-1:0]     regs_r [NUM_CH*DEPTH];
  logic [DW-1:0]     xa_data_rd_r;
  logic              xa_rd_vld_r;
  logic              xa_err_r;

  assign wa_valid = ~empty_s;
  assign pop_s    = wa_valid & wa_ready;

  // Strobe classification and address decode
  always_comb begin
    op_s       = IDLE;
    conflict_s = rst_n && xa_wr_s && xa_rd_s;
    sel_s      = xa_addr[SEL_W-1:0];
    ch_s       = sel_s[SEL_W-1:IDX_W];
    legal_s    = ((xa_addr >> SEL_W) == {AW{1'b0}});
    if (!rst_n) begin
      op_s = RESET;
    end else if (xa_wr_s && !xa_rd_s) begin
      op_s = WRITE;
    end else if (xa_rd_s && !xa_wr_s) begin
      op_s = READ;
    end else begin
      op_s = IDLE;
    end
  end

  // Write acceptance: a full FIFO still takes a push when it pops this cycle
  always_comb begin
    push_s     = {NUM_CH{1'b0}};
    can_push_s = (count_s[ch_s] < CW'(FIFO_DEPTH)) ||
                 (full_s[ch_s] && pop_s[ch_s]);
    wr_ok_s    = (op_s == WRITE) && legal_s && can_push_s;
    err_next_s = conflict_s ||
                 ((op_s == WRITE) && !wr_ok_s) ||
                 ((op_s == READ) && !legal_s);
    if (wr_ok_s) begin
      push_s[ch_s] = 1'b1;
    end else begin
      push_s = {NUM_CH{1'b0}};
    end
  end

  // Register file and registered xa responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH*DEPTH; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
      xa_data_rd_r <= {DW{1'b0}};
      xa_rd_vld_r  <= 1'b0;
      xa_err_r     <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        regs_r[sel_s] <= xa_data_wr;
      end
      if (op_s == READ) begin
        xa_data_rd_r <= legal_s ? regs_r[sel_s] : {DW{1'b0}};
      end
      xa_rd_vld_r <= (op_s == READ);
      xa_err_r    <= err_next_s;
    end
  end

  assign xa_data_rd = xa_data_rd_r;
  assign xa_rd_vld  = xa_rd_vld_r;
  assign xa_err     = xa_err_r;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sif_fifo #(
      .W     (AW + DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[c]),
      .din   ({xa_addr, xa_data_wr}),
      .pop   (pop_s[c]),
      .dout  (dout_s[c]),
      .empty (empty_s[c]),
      .full  (full_s[c]),
      .count (count_s[c])
    );
    assign wa_addr[c*AW +: AW]    = dout_s[c][AW+DW-1:DW];
    assign wa_data_wr[c*DW +: DW] = dout_s[c][DW-1:0];
  end

endmodule

// File: tb/tb_sif_mc_fwd.sv
// Directed table plus random traffic for sif_mc_fwd, checked every cycle
// against a queue-based reference model of the register file and channels.
module tb_sif_mc_fwd;
  import sif_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int DEP = 16;
  localparam int NCH = 2;
  localparam int FD  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 xa_wr_s;
  logic                 xa_rd_s;
  logic [AW-1:0]        xa_addr;
  logic [DW-1:0]        xa_data_wr;
  logic [DW-1:0]        xa_data_rd;
  logic                 xa_rd_vld;
  logic                 xa_err;
  logic [NCH-1:0]       wa_valid;
  logic [NCH-1:0]       wa_ready;
  logic [NCH*AW-1:0]    wa_addr;
  logic [NCH*DW-1:0]    wa_data_wr;

  sif_mc_fwd #(.AW(AW), .DW(DW), .DEPTH(DEP), .NUM_CH(NCH), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_addr    (xa_addr),
    .xa_data_wr (xa_data_wr),
    .xa_data_rd (xa_data_rd),
    .xa_rd_vld  (xa_rd_vld),
    .xa_err     (xa_err),
    .wa_valid   (wa_valid),
    .wa_ready   (wa_ready),
    .wa_addr    (wa_addr),
    .wa_data_wr (wa_data_wr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic [DW-1:0] m_reg [NCH*DEP];
  ent_t          m_q   [NCH][$];
  logic          m_err;
  logic          m_vld;
  logic [DW-1:0] m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH*DEP; i++) m_reg[i] = 16'h0000;
    for (int c = 0; c < NCH; c++) m_q[c].delete();
    m_err = 1'b0;
    m_vld = 1'b0;
    m_rd  = 16'h0000;
  endtask

  // Behaviour of one clock edge, from the values currently driven.
  task automatic model_step();
    bit   pops [NCH];
    bit   legal;
    bit   acc;
    int   flat;
    int   ch;
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int c = 0; c < NCH; c++) pops[c] = (m_q[c].size() > 0) && wa_ready[c];
      legal = (int'(xa_addr) < NCH*DEP);
      flat  = int'(xa_addr) % (NCH*DEP);
      ch    = flat / DEP;
      acc   = 0;
      m_err = 1'b0;
      m_vld = 1'b0;
      if (xa_wr_s && xa_rd_s) begin
        m_err = 1'b1;
      end else if (xa_wr_s) begin
        if (legal && (m_q[ch].size() < FD || pops[ch])) begin
          m_reg[flat] = xa_data_wr;
          acc = 1;
        end else begin
          m_err = 1'b1;
        end
      end else if (xa_rd_s) begin
        m_vld = 1'b1;
        m_rd  = legal ? m_reg[flat] : 16'h0000;
        m_err = !legal;
      end
      for (int c = 0; c < NCH; c++) if (pops[c]) void'(m_q[c].pop_front());
      if (acc) m_q[ch].push_back('{a: xa_addr, d: xa_data_wr});
    end
  endtask

  task automatic compare_model();
    chk("m_err", 32'(xa_err), 32'(m_err));
    chk("m_vld", 32'(xa_rd_vld), 32'(m_vld));
    chk("m_rd",  32'(xa_data_rd), 32'(m_rd));
    for (int c = 0; c < NCH; c++) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = 16'h0000;
      ed = 16'h0000;
      if (m_q[c].size() > 0) begin
        ea = m_q[c][0].a;
        ed = m_q[c][0].d;
      end
      chk($sformatf("wa_valid[%0d]", c), 32'(wa_valid[c]), 32'(m_q[c].size() > 0));
      chk($sformatf("wa_addr[%0d]", c), 32'(wa_addr[c*AW +: AW]), 32'(ea));
      chk($sformatf("wa_data[%0d]", c), 32'(wa_data_wr[c*DW +: DW]), 32'(ed));
    end
  endtask

  task automatic cycle(input logic r, input logic wr, input logic rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NCH-1:0] rdy);
    rst_n      = r;
    xa_wr_s    = wr;
    xa_rd_s    = rd;
    xa_addr    = a;
    xa_data_wr = d;
    wa_ready   = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic           wr;
    logic           rd;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [NCH-1:0] rdy;
    logic           e_err;
    logic           e_vld;
    logic [DW-1:0]  e_rd;
  } vec_t;

  vec_t tbl [35];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [NCH-1:0] rdy,
                              input logic ee, input logic ev, input logic [DW-1:0] er);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.data = d; v.rdy = rdy;
    v.e_err = ee; v.e_vld = ev; v.e_rd = er;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1'b0, 1'b1, 16'h0003, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000);
    tbl[1]  = mk(1'b1, 1'b0, 16'h0005, 16'hBEEF, 2'b01, 1'b0, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b0, 1'b1, 16'h0005, 16'h0000, 2'b01, 1'b0, 1'b1, 16'hBEEF);
    tbl[3]  = mk(1'b1, 1'b0, 16'h0012, 16'h1234, 2'b00, 1'b0, 1'b0, 16'hBEEF);
    tbl[4]  = mk(1'b0, 1'b1, 16'h0012, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h1234);
    tbl[5]  = mk(1'b0, 1'b1, 16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000);
    tbl[6]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b10, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 6; k++)
      tbl[7+k] = mk(1'b1, 1'b0, 16'h0010 + 16'(k), 16'h1000 + 16'(k), 2'b00,
                    (k >= 4) ? 1'b1 : 1'b0, 1'b0, 16'h0000);
    tbl[13] = mk(1'b0, 1'b1, 16'h0013, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h1003);
    tbl[14] = mk(1'b0, 1'b1, 16'h0014, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000);
    tbl[15] = mk(1'b0, 1'b1, 16'h0015, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < 4; k++)
      tbl[16+k] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b10, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++)
      tbl[20+k] = mk(1'b1, 1'b0, 16'(k), 16'hA000 + 16'(k), 2'b00, 1'b0, 1'b0, 16'h0000);
    tbl[24] = mk(1'b1, 1'b0, 16'h0001, 16'hAAAA, 2'b01, 1'b0, 1'b0, 16'h0000);
    tbl[25] = mk(1'b0, 1'b1, 16'h0001, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hAAAA);
    tbl[26] = mk(1'b1, 1'b0, 16'h0020, 16'h5555, 2'b00, 1'b1, 1'b0, 16'hAAAA);
    tbl[27] = mk(1'b0, 1'b1, 16'h0020, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0000);
    tbl[28] = mk(1'b0, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hA000);
    tbl[29] = mk(1'b1, 1'b1, 16'h0001, 16'h7777, 2'b00, 1'b1, 1'b0, 16'hA000);
    tbl[30] = mk(1'b0, 1'b1, 16'h0001, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hAAAA);
    for (int k = 0; k < 4; k++)
      tbl[31+k] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b01, 1'b0, 1'b0, 16'hAAAA);

    model_clear();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    chk("rst_data_rd", 32'(xa_data_rd), 32'h0);
    chk("rst_rd_vld",  32'(xa_rd_vld),  32'h0);
    chk("rst_err",     32'(xa_err),     32'h0);
    chk("rst_wa_valid", 32'(wa_valid),  32'h0);
    chk("rst_wa_addr", wa_addr,         32'h0);
    chk("rst_wa_data", wa_data_wr,      32'h0);

    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].rdy);
      chk($sformatf("tbl%0d_err", i), 32'(xa_err),     32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_vld", i), 32'(xa_rd_vld),  32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_rd", i),  32'(xa_data_rd), 32'(tbl[i].e_rd));
    end

    // Reset in the middle of a read burst cancels the response.
    cycle(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 2'b00);
    chk("burst_vld", 32'(xa_rd_vld), 32'h1);
    chk("burst_rd", 32'(xa_data_rd), 32'hAAAA);
    cycle(1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000, 2'b00);
    chk("midrst_vld", 32'(xa_rd_vld), 32'h0);
    chk("midrst_rd", 32'(xa_data_rd), 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 2'b00);
    chk("postrst_rd", 32'(xa_data_rd), 32'h0);
    chk("postrst_vld", 32'(xa_rd_vld), 32'h1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int            r;
      logic          rr;
      logic          wr;
      logic          rd;
      logic [AW-1:0] a;
      r  = int'($urandom_range(0, 15));
      rr = ($urandom_range(0, 127) != 0);
      wr = (r >= 1 && r <= 6) || (r == 0);
      rd = (r >= 7 && r <= 11) || (r == 0);
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = 16'($urandom_range(0, NCH*DEP-1));
      cycle(rr, wr, rd, a, 16'($urandom), 2'($urandom));
    end

    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
